// File: rtl/register_unit_pkg.sv
// Shared sizes and types for the RV32I integer register file.
package register_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned SP_IDX    = 2;
  localparam int unsigned ZERO_IDX  = 0;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      word_t;

  localparam word_t SP_RESET = 32'h0000_03FC;

  // True when an index names the hardwired-zero register.
  function automatic logic is_zero_idx(input reg_idx_t idx);
    return idx == REG_IDX_W'(ZERO_IDX);
  endfunction

endpackage

// File: rtl/register_unit_rdport.sv
// One combinational read port of the register file: x0 forced to zero,
// optional write-forwarding hit selects the in-flight write data.
module register_unit_rdport
  import register_unit_pkg::*;
(
  input  reg_idx_t idx,
  input  word_t    regs [NREGS],
  input  logic     byp_hit,
  input  word_t    byp_data,
  output word_t    data_c
);

  // Zero register wins, then forwarding, then stored contents.
  always_comb begin
    data_c = '0;
    if (is_zero_idx(idx)) begin
      data_c = '0;
    end else if (byp_hit) begin
      data_c = byp_data;
    end else begin
      data_c = regs[idx];
    end
  end

endmodule

// File: rtl/register_unit.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, x0 hardwired to zero, x2 resets to SP_RESET.
// Optional feature: define REGISTER_UNIT_BYPASS_EN for same-cycle
// write-to-read forwarding (suppressed while rst is high).
module register_unit
  import register_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  reg_idx_t rs1,
  input  reg_idx_t rs2,
  input  reg_idx_t rd,
  input  word_t    DataWr,
  input  logic     RUWr,
  output word_t    RURs1,
  output word_t    RURs2
);

  word_t regs [NREGS];
  logic  wr_en;
  logic  hit1;
  logic  hit2;

  // A write only lands on a nonzero destination outside reset.
  assign wr_en = RUWr && !is_zero_idx(rd);

  // Storage: synchronous reset has priority over the write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[REG_IDX_W'(i)] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else if (wr_en) begin
      regs[rd] <= DataWr;
    end
  end

`ifdef REGISTER_UNIT_BYPASS_EN
  // Forward the pending write to any port reading the same register.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    if (wr_en && !rst) begin
      hit1 = (rs1 == rd);
      hit2 = (rs2 == rd);
    end
  end
`else
  // No forwarding: reads during a write see the pre-edge value.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
  end
`endif

  register_unit_rdport u_rd1 (
    .idx      (rs1),
    .regs     (regs),
    .byp_hit  (hit1),
    .byp_data (DataWr),
    .data_c   (RURs1)
  );

  register_unit_rdport u_rd2 (
    .idx      (rs2),
    .regs     (regs),
    .byp_hit  (hit2),
    .byp_data (DataWr),
    .data_c   (RURs2)
  );

endmodule

// File: tb/tb_register_unit.sv
// Directed self-checking bench for register_unit.
module tb_register_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] DataWr;
  logic        RUWr;
  logic [31:0] RURs1;
  logic [31:0] RURs2;

  int n_checks;
  int n_errors;

  register_unit dut (
    .clk    (clk),
    .rst    (rst),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (rd),
    .DataWr (DataWr),
    .RUWr   (RUWr),
    .RURs1  (RURs1),
    .RURs2  (RURs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [31:0] val);
    rd     = idx;
    DataWr = val;
    RUWr   = 1'b1;
    tick();
    RUWr   = 1'b0;
    #1;
  endtask

  task automatic rd_pair(input logic [4:0] a, input logic [4:0] b);
    rs1 = a;
    rs2 = b;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; RUWr = 1'b0; rd = '0; DataWr = '0; rs1 = '0; rs2 = '0;

    // Reset state
    tick();
    rst = 1'b0;
    rd_pair(5'd2, 5'd5);
    check("rst_sp", RURs1, 32'h0000_03FC);
    check("rst_x5", RURs2, 32'h0);
    rd_pair(5'd31, 5'd0);
    check("rst_x31", RURs1, 32'h0);
    check("rst_x0", RURs2, 32'h0);

    // Basic write/read on both ports
    wr(5'd5, 32'd1234);
    rd_pair(5'd5, 5'd5);
    check("wr_x5_p1", RURs1, 32'd1234);
    check("wr_x5_p2", RURs2, 32'd1234);

    // x0 protection
    wr(5'd0, 32'hDEAD_BEEF);
    rd_pair(5'd0, 5'd2);
    check("x0_p1", RURs1, 32'h0);
    check("x0_sp_kept", RURs2, 32'h0000_03FC);

    // Write enable low leaves state alone
    wr(5'd3, 32'd9);
    rd = 5'd3; DataWr = 32'h0000_AAAA; RUWr = 1'b0;
    tick();
    rd_pair(5'd3, 5'd5);
    check("noen_x3", RURs1, 32'd9);
    check("noen_x5", RURs2, 32'd1234);

    // Read during write of the same register
    wr(5'd7, 32'd10);
    rd = 5'd7; DataWr = 32'd99; RUWr = 1'b1;
    rd_pair(5'd7, 5'd3);
`ifdef REGISTER_UNIT_BYPASS_EN
    check("rdw_before", RURs1, 32'd99);
`else
    check("rdw_before", RURs1, 32'd10);
`endif
    check("rdw_other", RURs2, 32'd9);
    tick();
    RUWr = 1'b0;
    #1;
    check("rdw_after", RURs1, 32'd99);

    // Reset arriving together with a write
    wr(5'd9, 32'd77);
    rd_pair(5'd9, 5'd2);
    check("pre_rst_x9", RURs1, 32'd77);
    rst = 1'b1; RUWr = 1'b1; rd = 5'd9; DataWr = 32'd55;
    #1;
    check("in_rst_x9", RURs1, 32'd77);
    tick();
    rst = 1'b0; RUWr = 1'b0;
    #1;
    check("rst_wr_x9", RURs1, 32'h0);
    check("rst_wr_sp", RURs2, 32'h0000_03FC);
    rd_pair(5'd5, 5'd7);
    check("rst_clr_x5", RURs1, 32'h0);
    check("rst_clr_x7", RURs2, 32'h0);

    // Sweep: x_i = 3*i, read every pair (i, 31-i)
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i * 3));
    end
    for (int i = 0; i < 32; i++) begin
      rd_pair(5'(i), 5'(31 - i));
      check($sformatf("sweep_p1_x%0d", i), RURs1, 32'(i * 3));
      check($sformatf("sweep_p2_x%0d", 31 - i), RURs2, 32'((31 - i) * 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
